pwm_fade_multi: RTL and testbench

// Multi-channel PWM LED fader; parametrised successor of the single-channel fade-out block.

---
 rtl/pwm_fade_multi.sv | 80 ++++++++
 tb/tb_pwm_fade_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_multi.sv
// pwm_fade_multi: multi-channel PWM LED fader sharing one free-running PWM counter;
// each channel runs its own fade-out / fade-in / breathe / off sequencer.
module pwm_fade_multi #(
    parameter int NumChannels = 4,
    parameter int CounterSize = 7,
    parameter int NumTicks    = (1 << 18) - 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumChannels-1:0]   impulse_i,
    input  logic [2*NumChannels-1:0] mode_i,
    output logic [NumChannels-1:0]   modulated_o,
    output logic [NumChannels-1:0]   busy_o
);
    localparam int StepW = (NumTicks < 1) ? 1 : $clog2(NumTicks + 1);
    localparam logic [CounterSize-1:0] CounterMax = {CounterSize{1'b1}};
    localparam logic [StepW-1:0] StepMax = StepW'(NumTicks);

    typedef enum logic [1:0] {IDLE, FADE_DOWN, FADE_UP} state_e;
    typedef enum logic [1:0] {FADE_OUT = 2'b00, FADE_IN = 2'b01, BREATHE = 2'b10, OFF = 2'b11} mode_e;

    if (NumChannels < 1 || CounterSize < 1 || NumTicks < 1) begin : g_bad_params
        $fatal(1, "pwm_fade_multi: NumChannels, CounterSize and NumTicks must all be >= 1");
    end

    logic [CounterSize-1:0] pwm_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 1'b1;
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        state_e                 state_q, state_d;
        mode_e                  mode_q, mode_d, mode_in;
        logic [CounterSize-1:0] level_q, level_d;
        logic [StepW-1:0]       step_q, step_d;
        logic                   step_evt;

        assign mode_in  = mode_e'(mode_i[2*c +: 2]);
        assign step_evt = (state_q != IDLE) && (step_q == StepMax);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                mode_q  <= FADE_OUT;
                level_q <= '0;
                step_q  <= '0;
            end else begin
                state_q <= state_d;
                mode_q  <= mode_d;
                level_q <= level_d;
                step_q  <= step_d;
            end
        end

        // Turnaround happens on the step that lands on the end value, so level never wraps.
        always_comb begin
            state_d = state_q;
            mode_d  = mode_q;
            level_d = level_q;
            step_d  = (state_q == IDLE || step_evt) ? '0 : step_q + 1'b1;
            if (impulse_i[c]) begin
                mode_d  = mode_in;
                step_d  = '0;
                level_d = (mode_in == FADE_OUT) ? CounterMax : '0;
                state_d = (mode_in == FADE_OUT) ? FADE_DOWN : (mode_in == OFF) ? IDLE : FADE_UP;
            end else if (step_evt && state_q == FADE_DOWN) begin
                level_d = level_q - 1'b1;
                if (level_q == CounterSize'(1)) state_d = (mode_q == BREATHE) ? FADE_UP : IDLE;
            end else if (step_evt && state_q == FADE_UP) begin
                level_d = level_q + 1'b1;
                if (level_q == CounterMax - 1'b1) state_d = (mode_q == BREATHE) ? FADE_DOWN : IDLE;
            end
        end

        assign modulated_o[c] = pwm_cnt < level_q;
        assign busy_o[c]      = state_q != IDLE;
    end
endmodule

// File: tb/tb_pwm_fade_multi.sv
// tb_pwm_fade_multi: checks pwm_fade_multi (2 channels, Max=7, 4-cycle step) against a
// model that derives each channel's level from the cycles elapsed since its last trigger.
module tb_pwm_fade_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] imp = '0;
    logic [3:0] mode = '0;
    logic [1:0] mod_o, busy;
    int total = 0;
    int bad = 0;

    // Reference model: PWM phase = cycles since reset; level follows from steps since release.
    int age = 0;
    bit act[2] = '{0, 0};
    int md[2] = '{0, 0};
    int since[2] = '{0, 0};

    pwm_fade_multi #(.NumChannels(2), .CounterSize(3), .NumTicks(3)) dut (
        .clk_i(clk), .rst_i(rst), .impulse_i(imp), .mode_i(mode),
        .modulated_o(mod_o), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            age <= 0;
            act[0] <= 0;
            act[1] <= 0;
        end else begin
            age <= age + 1;
            for (int c = 0; c < 2; c++) begin
                if (imp[c]) begin
                    act[c] <= 1;
                    md[c] <= int'(mode[2*c +: 2]);
                    since[c] <= 0;
                end else if (act[c]) since[c] <= since[c] + 1;
            end
        end
    end

    function automatic int lvl(int c);
        int k = since[c] / 4;
        int p = k % 14;
        if (!act[c]) return 0;
        case (md[c])
            0: return (k >= 7) ? 0 : 7 - k;
            1: return (k >= 7) ? 7 : k;
            2: return (p <= 7) ? p : 14 - p;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] e_busy();
        logic [1:0] b;
        for (int c = 0; c < 2; c++) b[c] = act[c] && (md[c] == 2 || (md[c] < 2 && since[c] / 4 < 7));
        return b;
    endfunction

    function automatic logic [1:0] e_mod();
        logic [1:0] m;
        for (int c = 0; c < 2; c++) m[c] = (age % 8) < lvl(c);
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            imp = 2'($urandom);
            mode = 4'($urandom);
        end
        @(negedge clk);
        total++;
        if (mod_o !== 2'b00 || busy !== 2'b00) begin
            bad++;
            $display("FAIL reset_hold mod=%b busy=%b expected mod=00 busy=00", mod_o, busy);
        end
        rst = 1'b0;
        imp = '0;
        repeat (12) begin
            @(negedge clk);
            total++;
            if (mod_o !== 2'b00 || busy !== 2'b00) begin
                bad++;
                $display("FAIL reset_idle t=%0t mod=%b busy=%b expected 00/00", $time, mod_o, busy);
            end
        end
    endtask

    task automatic test_fade_out();
        imp = 2'b01;
        mode = 4'b0000;
        @(negedge clk);
        imp = '0;
        repeat (40) begin
            @(negedge clk);
            total++;
            if (mod_o !== e_mod() || busy !== e_busy()) begin
                bad++;
                $display("FAIL fade_out t=%0t mod=%b busy=%b expected mod=%b busy=%b", $time, mod_o, busy, e_mod(), e_busy());
            end
        end
    endtask

    task automatic test_fade_in_parallel();
        imp = 2'b01;
        mode = 4'b0000;
        @(negedge clk);
        imp = '0;
        repeat (3) @(negedge clk);
        imp = 2'b10;
        mode = 4'b0100;
        @(negedge clk);
        imp = '0;
        repeat (50) begin
            @(negedge clk);
            total++;
            if (mod_o !== e_mod() || busy !== e_busy()) begin
                bad++;
                $display("FAIL fade_in t=%0t mod=%b busy=%b expected mod=%b busy=%b", $time, mod_o, busy, e_mod(), e_busy());
            end
        end
    endtask

    task automatic test_breathe();
        imp = 2'b01;
        mode = 4'b0010;
        @(negedge clk);
        imp = '0;
        repeat (170) begin
            @(negedge clk);
            total++;
            if (mod_o !== e_mod() || busy[0] !== 1'b1) begin
                bad++;
                $display("FAIL breathe t=%0t mod=%b busy=%b expected mod=%b busy0=1", $time, mod_o, busy, e_mod());
            end
        end
    endtask

    task automatic test_off_retrigger();
        for (int r = 0; r < 2; r++) begin
            int n = 0;
            imp = 2'b01;
            mode = 4'b0010;
            @(negedge clk);
            imp = '0;
            while (lvl(0) != 5 && n < 100) begin
                @(negedge clk);
                n++;
                total++;
                if (mod_o !== e_mod() || busy !== e_busy()) begin
                    bad++;
                    $display("FAIL retrig_wait t=%0t mod=%b busy=%b expected mod=%b busy=%b", $time, mod_o, busy, e_mod(), e_busy());
                end
            end
            total++;
            if (n >= 100) begin
                bad++;
                $display("FAIL retrig_timeout level=%0d expected 5", lvl(0));
            end
            imp = 2'b01;
            mode = (r == 0) ? 4'b0011 : 4'b0000;
            @(negedge clk);
            imp = '0;
            total++;
            if (r == 0 && (mod_o[0] !== 1'b0 || busy[0] !== 1'b0)) begin
                bad++;
                $display("FAIL off_stop mod0=%b busy0=%b expected 0/0", mod_o[0], busy[0]);
            end
            if (r == 1 && busy[0] !== 1'b1) begin
                bad++;
                $display("FAIL retrig_busy busy0=%b expected 1", busy[0]);
            end
            repeat (35) begin
                @(negedge clk);
                total++;
                if (mod_o !== e_mod() || busy !== e_busy()) begin
                    bad++;
                    $display("FAIL retrig t=%0t mod=%b busy=%b expected mod=%b busy=%b", $time, mod_o, busy, e_mod(), e_busy());
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        imp = 2'b11;
        mode = 4'b1000;
        repeat (6) @(negedge clk);
        imp = '0;
        while (lvl(0) != 4 && n < 100) begin
            @(negedge clk);
            n++;
            total++;
            if (mod_o !== e_mod() || busy !== e_busy()) begin
                bad++;
                $display("FAIL b2b_wait t=%0t mod=%b busy=%b expected mod=%b busy=%b", $time, mod_o, busy, e_mod(), e_busy());
            end
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL b2b_timeout level=%0d expected 4", lvl(0));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (mod_o !== 2'b00 || busy !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset mod=%b busy=%b expected 00/00", mod_o, busy);
        end
        imp = 2'b01;
        mode = 4'b0000;
        @(negedge clk);
        imp = '0;
        repeat (16) begin
            @(negedge clk);
            total++;
            if (mod_o !== e_mod() || busy !== e_busy()) begin
                bad++;
                $display("FAIL post_reset t=%0t mod=%b busy=%b expected mod=%b busy=%b", $time, mod_o, busy, e_mod(), e_busy());
            end
        end
    endtask

    task automatic test_random();
        repeat (500) begin
            @(negedge clk);
            total++;
            if (mod_o !== e_mod() || busy !== e_busy()) begin
                bad++;
                $display("FAIL random t=%0t mod=%b busy=%b expected mod=%b busy=%b", $time, mod_o, busy, e_mod(), e_busy());
            end
            imp[0] = ($urandom_range(0, 39) == 0);
            imp[1] = ($urandom_range(0, 39) == 0);
            mode = 4'($urandom);
            rst = ($urandom_range(0, 299) == 0);
        end
        imp = '0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fade_out();
        test_fade_in_parallel();
        test_breathe();
        test_off_retrigger();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
